// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the single FIFO write port among N_REQ requesters
// in the wrclk domain. Round-robin arbitration with bounded bursts. Each
// requester uses a valid/ack handshake. The push stops while the FIFO is full.
`timescale 1ns/1ps

module fifo_wr_arbiter #(
    parameter  int N_REQ     = 4,
    parameter  int DW        = 8,
    parameter  int BURST_MAX = 4,
    localparam int OW        = $clog2(N_REQ),
    localparam int BW        = $clog2(BURST_MAX + 1)
) (
    input  logic                wrclk,
    input  logic                arst_n,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ*DW-1:0] data_i,
    output logic [N_REQ-1:0]    ack_o,
    input  logic                full_i,
    output logic                push_o,
    output logic [DW-1:0]       wdata_o,
    output logic [OW-1:0]       owner_o,
    output logic                busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_owner_q, last_owner_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

    logic            pick_valid;
    logic [OW-1:0]   pick;
    logic [OW-1:0]   cand;
    logic            xfer;
    logic [DW-1:0]   data_arr [N_REQ];

    // Unpack the flat requester data bus into per-requester words.
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g] = data_i[g*DW +: DW];
    end

    // Round-robin search: first requesting index after last_owner, wrapping.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = OW'((int'(last_owner_q) + i) % N_REQ);
            if (!pick_valid && req_i[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    // Next-state logic and handshake/push outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        xfer         = 1'b0;
        ack_o        = '0;
        push_o       = 1'b0;
        wdata_o      = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid && !full_i) begin
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end

            GRANT: begin
                // A cycle with reset asserted must not write the FIFO, even
                // though the state register still holds GRANT until the edge.
                xfer           = req_i[owner_q] & ~full_i & arst_n;
                ack_o[owner_q] = xfer;
                push_o         = xfer;
                if (xfer) begin
                    wdata_o = data_arr[owner_q];
                end

                if (!req_i[owner_q]) begin
                    // Requester dropped its request: give up the grant.
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                    beat_cnt_d   = '0;
                end else if (xfer) begin
                    if (beat_cnt_q == BW'(BURST_MAX - 1)) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                        beat_cnt_d   = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW'(1);
                    end
                end
                // full_i with request held: everything stays put (stall).
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and grant bookkeeping registers with synchronous active-low reset.
    always_ff @(posedge wrclk) begin
        // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of statement order.
        if (!arst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(N_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign owner_o = owner_q;
    assign busy_o  = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a short
// randomised run, with an expected-push scoreboard and per-cycle invariants.
`timescale 1ns/1ps

module tb_fifo_wr_arbiter;

    localparam int N_REQ     = 4;
    localparam int DW        = 8;
    localparam int BURST_MAX = 4;
    localparam int OW        = $clog2(N_REQ);
    localparam int DEPTH     = 32;

    logic                wrclk  = 1'b0;
    logic                arst_n = 1'b0;
    logic                full_i = 1'b0;
    logic [N_REQ-1:0]    req_i  = '0;
    logic [N_REQ*DW-1:0] data_i = '0;
    logic [N_REQ-1:0]    ack_o;
    logic                push_o;
    logic [DW-1:0]       wdata_o;
    logic [OW-1:0]       owner_o;
    logic                busy_o;

    always #5 wrclk = ~wrclk;

    fifo_wr_arbiter #(
        .N_REQ    (N_REQ),
        .DW       (DW),
        .BURST_MAX(BURST_MAX)
    ) dut (
        .wrclk  (wrclk),
        .arst_n (arst_n),
        .req_i  (req_i),
        .data_i (data_i),
        .ack_o  (ack_o),
        .full_i (full_i),
        .push_o (push_o),
        .wdata_o(wdata_o),
        .owner_o(owner_o),
        .busy_o (busy_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected pushes in order: {owner, data}.
    logic [OW+DW-1:0] exp_q [$];

    // Requester model: each requester presents its words in order and
    // advances on its own handshake.
    logic [DW-1:0] src  [N_REQ][DEPTH];
    int            head [N_REQ];
    int            tail [N_REQ];

    bit            rand_mode = 1'b0;
    int            rseq [N_REQ];
    int            burst = 0;
    logic [31:0]   trace = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic load(input int k, input logic [DW-1:0] d);
        src[k][tail[k]] = d;
        tail[k]++;
    endtask

    task automatic exp_push(input int k, input logic [DW-1:0] d);
        exp_q.push_back({OW'(k), d});
    endtask

    task automatic clear_src();
        for (int k = 0; k < N_REQ; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int k = 0; k < N_REQ; k++) begin
            if (head[k] != tail[k]) e = 1'b0;
        end
        return e;
    endfunction

    task automatic drive();
        for (int k = 0; k < N_REQ; k++) begin
            if (head[k] != tail[k]) begin
                req_i[k]            = 1'b1;
                data_i[k*DW +: DW] = src[k][head[k]];
            end else begin
                req_i[k]            = 1'b0;
                data_i[k*DW +: DW] = '0;
            end
        end
    endtask

    // Apply inputs, then at the falling edge check invariants and the scoreboard.
    task automatic settle();
        logic [OW+DW-1:0] e;
        drive();
        @(negedge wrclk);
        trace = {trace[30:0], push_o};
        check("ack_onehot", 32'($countones(ack_o) <= 1), 1);
        check("push_vs_ack", 32'(push_o), 32'(|ack_o));
        check("push_while_full", 32'(push_o & full_i), 0);
        if (!busy_o) burst = 0;
        if (push_o) begin
            burst++;
            check("burst_len", 32'(burst <= BURST_MAX), 1);
            check("ack_owner", 32'(ack_o), 32'(1) << owner_o);
            if (rand_mode) begin
                check("rand_src", 32'(wdata_o[7:6]), 32'(owner_o));
                check("rand_seq", 32'(wdata_o[5:0]), rseq[owner_o]);
                rseq[owner_o]++;
            end else if (exp_q.size() == 0) begin
                check("sb_unexpected_push", 32'(push_o), 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_owner", 32'(owner_o), 32'(e[DW +: OW]));
                check("sb_data", 32'(wdata_o), 32'(e[DW-1:0]));
            end
        end else begin
            check("wdata_idle", 32'(wdata_o), 0);
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (ack_o[k] && req_i[k]) head[k]++;
        end
    endtask

    task automatic tick();
        @(posedge wrclk);
        #1;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        full_i = 1'b0;
        clear_src();
        settle();
        tick();
        settle();
        check("rst_push", 32'(push_o), 0);
        check("rst_ack", 32'(ack_o), 0);
        check("rst_owner", 32'(owner_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_wdata", 32'(wdata_o), 0);
        tick();
        arst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            settle();
            if (all_empty() && !busy_o) done = 1'b1;
            tick();
        end
        check("drain_done", 32'(done), 1);
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_src();
        tick();
        do_reset();

        // Single requester: bursts of 4, one bubble, then the rest.
        for (int j = 0; j < 6; j++) begin
            load(0, 8'hA0 + 8'(j));
            exp_push(0, 8'hA0 + 8'(j));
        end
        trace = '0;
        for (int c = 0; c < 9; c++) begin
            settle();
            check("single_owner", 32'(owner_o), 0);
            tick();
        end
        check("single_push_pattern", 32'(trace[8:0]), 32'(9'b011110110));
        check("single_sb_drained", exp_q.size(), 0);

        // Reset mid-burst: no push in the reset cycle nor after it.
        for (int j = 0; j < 6; j++) load(0, 8'h90 + 8'(j));
        exp_push(0, 8'h90);
        exp_push(0, 8'h91);
        for (int c = 0; c < 3; c++) begin
            settle();
            tick();
        end
        arst_n = 1'b0;
        settle();
        check("midrst_push_in_cycle", 32'(push_o), 0);
        check("midrst_ack_in_cycle", 32'(ack_o), 0);
        tick();
        settle();
        check("midrst_push_after", 32'(push_o), 0);
        check("midrst_busy_after", 32'(busy_o), 0);
        check("midrst_owner_after", 32'(owner_o), 0);
        clear_src();
        tick();
        arst_n = 1'b1;
        check("midrst_sb_drained", exp_q.size(), 0);

        // All four requesting: grants 0,1,2,3,0, four words each.
        for (int k = 0; k < N_REQ; k++) begin
            for (int j = 0; j < 4; j++) load(k, 8'h40 + 8'(16*k + j));
        end
        for (int j = 4; j < 8; j++) load(0, 8'h40 + 8'(j));
        for (int k = 0; k < N_REQ; k++) begin
            for (int j = 0; j < 4; j++) exp_push(k, 8'h40 + 8'(16*k + j));
        end
        for (int j = 4; j < 8; j++) exp_push(0, 8'h40 + 8'(j));
        drain(60);

        // Early release: requester 1 stops after two words, requester 2 waits.
        load(1, 8'h50); load(1, 8'h51);
        load(2, 8'h60); load(2, 8'h61);
        exp_push(1, 8'h50); exp_push(1, 8'h51);
        exp_push(2, 8'h60); exp_push(2, 8'h61);
        trace = '0;
        for (int c = 0; c < 8; c++) begin
            settle();
            if (c == 4) begin
                check("early_bubble_busy", 32'(busy_o), 0);
                check("early_owner_hold", 32'(owner_o), 1);
            end
            tick();
        end
        check("early_push_pattern", 32'(trace[7:0]), 32'(8'b01100110));
        check("early_sb_drained", exp_q.size(), 0);

        // Full stall for three cycles at beat 2 of owner 0.
        for (int j = 0; j < 4; j++) begin
            load(0, 8'h70 + 8'(j));
            exp_push(0, 8'h70 + 8'(j));
        end
        trace = '0;
        for (int c = 0; c < 9; c++) begin
            full_i = (c >= 3 && c <= 5);
            settle();
            if (full_i) begin
                check("stall_push", 32'(push_o), 0);
                check("stall_ack", 32'(ack_o), 0);
                check("stall_busy", 32'(busy_o), 1);
                check("stall_owner", 32'(owner_o), 0);
            end
            tick();
        end
        full_i = 1'b0;
        check("stall_push_pattern", 32'(trace[8:0]), 32'(9'b011000110));
        check("stall_sb_drained", exp_q.size(), 0);

        // Full in IDLE: no grant until full falls, then owner 0 right after reset.
        do_reset();
        for (int k = 0; k < N_REQ; k++) begin
            load(k, 8'h80 + 8'(k));
            exp_push(k, 8'h80 + 8'(k));
        end
        full_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("fullidle_busy", 32'(busy_o), 0);
            check("fullidle_req", 32'(req_i), 32'hF);
            tick();
        end
        full_i = 1'b0;
        settle();
        check("fullidle_release_busy", 32'(busy_o), 0);
        tick();
        settle();
        check("fullidle_grant_busy", 32'(busy_o), 1);
        check("fullidle_grant_owner", 32'(owner_o), 0);
        check("fullidle_grant_push", 32'(push_o), 1);
        tick();
        drain(40);

        // Randomised full flag: per-requester data arrives complete and in order.
        do_reset();
        rand_mode = 1'b1;
        for (int k = 0; k < N_REQ; k++) begin
            rseq[k] = 0;
            for (int j = 0; j < 12; j++) load(k, {2'(k), 6'(j)});
        end
        begin
            bit done = 1'b0;
            for (int i = 0; i < 1000 && !done; i++) begin
                full_i = ($urandom_range(0, 3) == 0);
                settle();
                if (all_empty() && !busy_o) done = 1'b1;
                tick();
            end
            check("rand_done", 32'(done), 1);
        end
        full_i = 1'b0;
        for (int k = 0; k < N_REQ; k++) check("rand_count", rseq[k], 12);
        rand_mode = 1'b0;
        check("final_sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
